// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: widths, FSM encoding and the Rcon table.
package aes_pkg;

   localparam int AES_NR = 10;
   localparam int WORD_W = 32;
   localparam int KEY_W  = 128;

   // Key-expansion sequencer states; exposed on the top for checker binding.
   typedef enum logic [2:0] {
      KS_IDLE   = 3'd0,
      KS_LOAD   = 3'd1,
      KS_G_REQ  = 3'd2,
      KS_G_WAIT = 3'd3,
      KS_XOR    = 3'd4,
      KS_DONE   = 3'd5
   } key_state_t;

   // Round constant byte for round r (1..10); any other index yields 0.
   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] v;
      case (r)
         4'd1:    v = 8'h01;
         4'd2:    v = 8'h02;
         4'd3:    v = 8'h04;
         4'd4:    v = 8'h08;
         4'd5:    v = 8'h10;
         4'd6:    v = 8'h20;
         4'd7:    v = 8'h40;
         4'd8:    v = 8'h80;
         4'd9:    v = 8'h1b;
         4'd10:   v = 8'h36;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/rk_regfile.sv
// Round-key storage: one write port, one registered read port.
// Out-of-range addresses read as zero and never write.
module rk_regfile
   import aes_pkg::*;
#(
   parameter int NUM_ENTRIES = AES_NR + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_we,
   input  logic [3:0]       i_waddr,
   input  logic [KEY_W-1:0] i_wdata,
   input  logic [3:0]       i_raddr,
   output logic [KEY_W-1:0] o_rdata
);

   localparam logic [3:0] LAST_ADDR = 4'(NUM_ENTRIES - 1);

   logic [KEY_W-1:0] r_mem [NUM_ENTRIES];

   // Storage: cleared by reset, written one entry per cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we && (i_waddr <= LAST_ADDR)) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Registered read with range check; one-cycle latency from address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_rdata <= '0;
      end else if (i_raddr <= LAST_ADDR) begin
         o_rdata <= r_mem[i_raddr];
      end else begin
         o_rdata <= '0;
      end
   end

endmodule

// File: rtl/key_sched_ctrl.sv
// AES-128 key-expansion sequencer. Drives an external G unit over an
// enable/done handshake, runs the four-word XOR cascade and stores every
// round key in rk_regfile for the round engine to read.
//
// G handshake: g_enable is a single-cycle request carrying g_in/g_round;
// the first g_done seen while waiting delivers g_out and completes the
// request. g_done in any other state carries no meaning and is dropped.
module key_sched_ctrl
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS = AES_NR,
   parameter int G_TIMEOUT  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [KEY_W-1:0]   key_in,
   output logic               busy,
   output logic               done,
   output logic               keys_valid,
   output logic               err,
   output logic               g_enable,
   output logic [WORD_W-1:0]  g_in,
   output logic [3:0]         g_round,
   input  logic [WORD_W-1:0]  g_out,
   input  logic               g_done,
   input  logic [3:0]         rk_addr,
   output logic [KEY_W-1:0]   rk_data,
   output key_state_t         o_dbg_state
);

   localparam int              TMO_W     = $clog2(G_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(G_TIMEOUT - 1);
   localparam logic [3:0]      LAST_RND  = 4'(NUM_ROUNDS);

   key_state_t        r_state;
   key_state_t        w_next;
   logic [WORD_W-1:0] r_w0, r_w1, r_w2, r_w3, r_gw;
   logic [WORD_W-1:0] w_x0, w_x1, w_x2, w_x3;
   logic [3:0]        r_round;
   logic [TMO_W-1:0]  r_tmo;
   logic              r_keys_valid;
   logic              r_err;
   logic              w_tmo_hit;
   logic              w_rk_we;
   logic [3:0]        w_rk_waddr;
   logic [KEY_W-1:0]  w_rk_wdata;

   // XOR cascade feeding the next round key.
   assign w_x0 = r_w0 ^ r_gw;
   assign w_x1 = r_w1 ^ w_x0;
   assign w_x2 = r_w2 ^ w_x1;
   assign w_x3 = r_w3 ^ w_x2;

   // Last waiting cycle without an answer from G.
   assign w_tmo_hit = (r_state == KS_G_WAIT) && !g_done && (r_tmo == TMO_LAST);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= KS_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         KS_IDLE:   if (start) w_next = KS_LOAD;
         KS_LOAD:   w_next = KS_G_REQ;
         KS_G_REQ:  w_next = KS_G_WAIT;
         KS_G_WAIT: begin
            if (g_done) begin
               w_next = KS_XOR;
            end else if (w_tmo_hit) begin
               w_next = KS_IDLE;
            end
         end
         KS_XOR:    w_next = (r_round == LAST_RND) ? KS_DONE : KS_G_REQ;
         KS_DONE:   w_next = KS_IDLE;
         default:   w_next = KS_IDLE;
      endcase
   end

   // Outputs and key-file write port, decoded from the current state.
   always_comb begin
      busy        = (r_state != KS_IDLE);
      done        = (r_state == KS_DONE);
      g_enable    = (r_state == KS_G_REQ);
      g_in        = r_w3;
      g_round     = r_round;
      keys_valid  = r_keys_valid;
      err         = r_err | w_tmo_hit;
      o_dbg_state = r_state;
      w_rk_we     = (r_state == KS_LOAD) || (r_state == KS_XOR);
      w_rk_waddr  = (r_state == KS_LOAD) ? 4'd0 : r_round;
      w_rk_wdata  = (r_state == KS_LOAD) ? {r_w0, r_w1, r_w2, r_w3}
                                         : {w_x0, w_x1, w_x2, w_x3};
   end

   // Working words, round counter, timeout counter and status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_w0         <= '0;
         r_w1         <= '0;
         r_w2         <= '0;
         r_w3         <= '0;
         r_gw         <= '0;
         r_round      <= '0;
         r_tmo        <= '0;
         r_keys_valid <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         case (r_state)
            KS_IDLE: begin
               if (start) begin
                  r_w0         <= key_in[127:96];
                  r_w1         <= key_in[95:64];
                  r_w2         <= key_in[63:32];
                  r_w3         <= key_in[31:0];
                  r_round      <= 4'd1;
                  r_keys_valid <= 1'b0;
                  r_err        <= 1'b0;
               end
            end
            KS_G_REQ: r_tmo <= '0;
            KS_G_WAIT: begin
               if (g_done) begin
                  r_gw <= g_out;
               end else if (w_tmo_hit) begin
                  r_err <= 1'b1;
               end else begin
                  r_tmo <= r_tmo + TMO_W'(1);
               end
            end
            KS_XOR: begin
               r_w0 <= w_x0;
               r_w1 <= w_x1;
               r_w2 <= w_x2;
               r_w3 <= w_x3;
               if (r_round != LAST_RND) begin
                  r_round <= r_round + 4'd1;
               end
            end
            KS_DONE: r_keys_valid <= 1'b1;
            default: ;
         endcase
      end
   end

   rk_regfile #(
      .NUM_ENTRIES(NUM_ROUNDS + 1)
   ) u_rk_regfile (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_rk_we),
      .i_waddr (w_rk_waddr),
      .i_wdata (w_rk_wdata),
      .i_raddr (rk_addr),
      .o_rdata (rk_data)
   );

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Bench for key_sched_ctrl: behavioural G unit with fixed latency, a
// word-array AES-128 key-expansion reference, and directed scenarios with
// random keys.
module tb_key_sched_ctrl;
   import aes_pkg::*;

   localparam int G_LAT   = 6;
   localparam int EXP_LAT = 83;

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   logic         clk = 1'b0;
   logic         rst, start;
   logic [127:0] key_in;
   logic         busy, done, keys_valid, err, g_enable, g_done;
   logic [31:0]  g_in, g_out;
   logic [3:0]   g_round, rk_addr;
   logic [127:0] rk_data;
   key_state_t   dbg_state;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   logic [127:0] exp_rk [16];
   logic [127:0] exp_q [$];

   always #5 clk = ~clk;

   key_sched_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .key_in(key_in),
      .busy(busy), .done(done), .keys_valid(keys_valid), .err(err),
      .g_enable(g_enable), .g_in(g_in), .g_round(g_round),
      .g_out(g_out), .g_done(g_done), .rk_addr(rk_addr), .rk_data(rk_data),
      .o_dbg_state(dbg_state)
   );

   // ---------------- reference functions ----------------
   function automatic logic [7:0] sub_byte(input logic [7:0] b);
      logic [2047:0] t;
      t = SBOX;
      return t[2047 - 8*int'(b) -: 8];
   endfunction

   function automatic logic [31:0] g_fn(input logic [31:0] w, input logic [3:0] r);
      logic [31:0] rot;
      rot = {w[23:0], w[31:24]};
      return {sub_byte(rot[31:24]) ^ rcon(r), sub_byte(rot[23:16]),
              sub_byte(rot[15:8]), sub_byte(rot[7:0])};
   endfunction

   // FIPS-197 word recurrence; addresses beyond the last round key read 0.
   task automatic expand(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) t = g_fn(t, 4'(i / 4));
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 16; r++) begin
         exp_rk[r] = (r <= AES_NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
      end
   endtask

   // ---------------- behavioural G unit ----------------
   int          tcyc = 0;
   int          due_q [$];
   logic [31:0] val_q [$];
   int          hold_left = 0;
   logic [31:0] cur_out = '0;
   bit          g_never = 0;
   bit          g_spur = 0;
   int          g_hold = 1;

   initial begin
      g_done = 1'b0;
      g_out  = '0;
   end

   always begin
      @(posedge clk);
      #1;
      tcyc++;
      if (rst) begin
         due_q.delete();
         val_q.delete();
         hold_left = 0;
         g_done = 1'b0;
         g_out = '0;
      end else begin
         if (due_q.size() > 0 && due_q[0] == tcyc) begin
            void'(due_q.pop_front());
            cur_out = val_q.pop_front();
            hold_left = g_hold;
         end
         if (hold_left > 0) begin
            g_done = 1'b1;
            g_out = cur_out;
            hold_left--;
         end else begin
            g_done = g_spur && (!busy || g_enable);
            g_out = $urandom;
         end
         if (g_enable && !g_never) begin
            due_q.push_back(tcyc + G_LAT);
            val_q.push_back(g_fn(g_in, g_round));
         end
      end
   end

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rand_key();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Pulse start in cycle 0; returns inclusive start-to-done cycle count.
   task automatic run_key(input logic [127:0] k, output int lat, output bit to);
      int cyc;
      key_in = k;
      start = 1'b1;
      step();
      start = 1'b0;
      cyc = 1;
      while (done !== 1'b1 && cyc < 300) begin
         step();
         cyc++;
      end
      to = (done !== 1'b1);
      lat = cyc + 1;
   endtask

   task automatic sweep(input string tag);
      for (int a = 0; a < 16; a++) exp_q.push_back(exp_rk[a]);
      for (int a = 0; a < 16; a++) begin
         rk_addr = 4'(a);
         step();
         check($sformatf("%s_rd%0d", tag, a), rk_data, exp_q.pop_front());
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int           lat, dc0, cyc;
      bit           to;
      logic [127:0] ka, kb;

      rst = 1'b1; start = 1'b0; key_in = '0; rk_addr = '0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_done", 128'(done), 128'd0);
      check("rst_keys_valid", 128'(keys_valid), 128'd0);
      check("rst_err", 128'(err), 128'd0);
      check("rst_g_enable", 128'(g_enable), 128'd0);
      check("rst_g_in", 128'(g_in), 128'd0);
      check("rst_g_round", 128'(g_round), 128'd0);
      check("rst_rk_data", rk_data, 128'd0);
      rst = 1'b0;
      step();
      rk_addr = 4'd10;
      step();
      check("rst_rk10_zero", rk_data, 128'd0);

      // FIPS-197 vector
      run_key(FIPS_KEY, lat, to);
      check("fips_timeout", 128'(to), 128'd0);
      check("fips_latency", 128'(lat), 128'(EXP_LAT));
      step();
      check("fips_keys_valid", 128'(keys_valid), 128'd1);
      check("fips_busy_after", 128'(busy), 128'd0);
      check("fips_done_count", 128'(done_cnt), 128'd1);
      expand(FIPS_KEY);
      sweep("fips");
      rk_addr = 4'd1;
      step();
      check("fips_rk1_vector", rk_data, FIPS_RK1);
      rk_addr = 4'd10;
      step();
      check("fips_rk10_vector", rk_data, FIPS_RK10);

      // random keys
      for (int n = 0; n < 2; n++) begin
         ka = rand_key();
         run_key(ka, lat, to);
         check($sformatf("rnd%0d_latency", n), 128'(lat), 128'(EXP_LAT));
         step();
         check($sformatf("rnd%0d_keys_valid", n), 128'(keys_valid), 128'd1);
         expand(ka);
         sweep($sformatf("rnd%0d", n));
      end

      // G never answers
      g_never = 1;
      dc0 = done_cnt;
      ka = rand_key();
      key_in = ka;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      check("tmo_g_enable", 128'(g_enable), 128'd1);
      check("tmo_g_round", 128'(g_round), 128'd1);
      check("tmo_g_in", 128'(g_in), 128'(ka[31:0]));
      check("tmo_keys_valid_cleared", 128'(keys_valid), 128'd0);
      repeat (15) step();
      check("tmo_err_early", 128'(err), 128'd0);
      step();
      check("tmo_err_at_limit", 128'(err), 128'd1);
      check("tmo_busy_at_limit", 128'(busy), 128'd1);
      step();
      check("tmo_busy_after", 128'(busy), 128'd0);
      check("tmo_err_sticky", 128'(err), 128'd1);
      step();
      check("tmo_keys_valid", 128'(keys_valid), 128'd0);
      check("tmo_no_done", 128'(done_cnt), 128'(dc0));
      g_never = 0;

      // second start during expansion is ignored
      dc0 = done_cnt;
      ka = rand_key();
      kb = rand_key();
      key_in = ka;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      check("restart_err_cleared", 128'(err), 128'd0);
      repeat (28) step();
      key_in = kb;
      start = 1'b1;
      step();
      start = 1'b0;
      cyc = 31;
      while (done !== 1'b1 && cyc < 300) begin
         step();
         cyc++;
      end
      check("ignore_latency", 128'(cyc + 1), 128'(EXP_LAT));
      repeat (3) step();
      check("ignore_done_count", 128'(done_cnt - dc0), 128'd1);
      expand(ka);
      sweep("ignore");

      // asynchronous reset in round-5 G_WAIT
      dc0 = done_cnt;
      key_in = FIPS_KEY;
      start = 1'b1;
      step();
      start = 1'b0;
      cyc = 0;
      while (!(g_enable === 1'b1 && g_round === 4'd5) && cyc < 200) begin
         step();
         cyc++;
      end
      check("rst5_reached_round5", 128'(g_round), 128'd5);
      step();
      step();
      #3 rst = 1'b1;
      #1;
      check("rst5_busy", 128'(busy), 128'd0);
      check("rst5_g_round", 128'(g_round), 128'd0);
      check("rst5_g_in", 128'(g_in), 128'd0);
      check("rst5_rk_data", rk_data, 128'd0);
      check("rst5_err", 128'(err), 128'd0);
      @(posedge clk);
      #2 rst = 1'b0;
      rk_addr = 4'd1;
      step();
      check("rst5_file_cleared", rk_data, 128'd0);
      check("rst5_no_done", 128'(done_cnt), 128'(dc0));
      run_key(FIPS_KEY, lat, to);
      check("rst5_latency", 128'(lat), 128'(EXP_LAT));
      rk_addr = 4'd10;
      step();
      step();
      check("rst5_rk10", rk_data, FIPS_RK10);

      // spurious g_done and 3-cycle g_done
      g_spur = 1;
      g_hold = 3;
      repeat (3) step();
      check("spur_idle_busy", 128'(busy), 128'd0);
      dc0 = done_cnt;
      ka = rand_key();
      run_key(ka, lat, to);
      check("spur_latency", 128'(lat), 128'(EXP_LAT));
      step();
      check("spur_keys_valid", 128'(keys_valid), 128'd1);
      check("spur_done_count", 128'(done_cnt - dc0), 128'd1);
      expand(ka);
      sweep("spur");
      g_spur = 0;
      g_hold = 1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
